qed_dup_replay: RTL and testbench

Buffered issue stage for the SQED flow that replaces single-cycle, combinational instruction duplication. While QED is enabled, it passes original instructions through to the core and records each duplicable one in an in-order buffer. On request, or when the buffer fills, it replays the recorded instructions as duplicates remapped into the upper register half and the tagged memory region. It sits between the instruction-fetch mux and the core's instruction input.

---
 rtl/qed_dup_replay_if.sv | 20 ++
 rtl/qed_dup_replay.sv | 202 ++++++++++++++++++++
 tb/tb_qed_dup_replay.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qed_dup_replay_if.sv
// Handshake bundle between the fetch mux (master) and the QED issue stage (slave).
interface qed_dup_replay_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic        out_is_dup;
  logic        out_ready;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_is_dup
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_is_dup
  );
endinterface

// File: rtl/qed_dup_replay.sv
// Buffered SQED issue stage: passes originals through, records duplicable ones,
// then replays them as duplicates remapped to the upper register half and the
// tagged memory region.
module qed_dup_replay #(
  parameter int                   DEPTH     = 8,
  parameter int                   MEM_TAG_W = 2,
  parameter logic [MEM_TAG_W-1:0] MEM_TAG   = 2'b01,
  parameter logic [3:0]           CLASS_EN  = 4'b1111
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       exec_dup,
  qed_dup_replay_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic                       orig_violation
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ORIG, REPLAY} state_t;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            out_is_dup_q, out_is_dup_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   buf_count_q, buf_count_d;
  logic            orig_violation_q, orig_violation_d;
  logic            live_q, live_d;
  logic [31:0]     buf_q [DEPTH];
  logic [31:0]     buf_d [DEPTH];

  logic            slot_free;
  logic            in_ready;
  logic            accept;
  logic            push;
  logic            pop;
  logic            flush;
  logic [CW-1:0]   count_after_push;

  // x0 stays x0; every other register lands in the upper half x16..x31
  function automatic logic [4:0] map_reg(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
  endfunction

  // bit0 I-ALU, bit1 LW, bit2 R, bit3 SW, masked by the class enables
  function automatic logic [3:0] dec_class(input logic [31:0] i);
    logic [3:0] c;
    c[0] = (i[6:0] == 7'b0010011);
    c[1] = (i[6:0] == 7'b0000011) && (i[14:12] == 3'b010);
    c[2] = (i[6:0] == 7'b0110011);
    c[3] = (i[6:0] == 7'b0100011) && (i[14:12] == 3'b010);
    return c & CLASS_EN;
  endfunction

  // An original touching x16..x31 would collide with its own duplicate
  function automatic logic uses_upper(input logic [31:0] i);
    logic [3:0] c;
    c = dec_class(i);
    return ((c[0] | c[1]) & (i[11] | i[19])) |
           (c[2] & (i[11] | i[19] | i[24])) |
           (c[3] & (i[19] | i[24]));
  endfunction

  // Build the duplicate: remap used registers, overwrite immediate MSBs with the tag
  function automatic logic [31:0] remap(input logic [31:0] i);
    logic [3:0]  c;
    logic [11:0] imm;
    logic [6:0]  imm_hi;
    logic [31:0] r;
    c      = dec_class(i);
    r      = i;
    imm    = i[31:20];
    imm_hi = i[31:25];
    imm[11 -: MEM_TAG_W]   = MEM_TAG;
    imm_hi[6 -: MEM_TAG_W] = MEM_TAG;
    if (c[0] | c[1]) begin
      r = {imm, map_reg(i[19:15]), i[14:12], map_reg(i[11:7]), i[6:0]};
    end else if (c[2]) begin
      r = {i[31:25], map_reg(i[24:20]), map_reg(i[19:15]), i[14:12],
           map_reg(i[11:7]), i[6:0]};
    end else if (c[3]) begin
      r = {imm_hi, map_reg(i[24:20]), map_reg(i[19:15]), i[14:12],
           i[11:7], i[6:0]};
    end
    return r;
  endfunction

  // Handshake qualification and next-state selection
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    pop       = 1'b0;
    slot_free = !out_valid_q || bus.out_ready;
    case (state_q)
      IDLE:    in_ready = live_q && slot_free;
      ORIG:    in_ready = live_q && slot_free && (buf_count_q != FULL);
      REPLAY:  pop      = slot_free && (buf_count_q != '0);
      default: in_ready = 1'b0;
    endcase
    accept           = bus.in_valid && in_ready;
    push             = accept && (state_q == ORIG) && (dec_class(bus.in_instr) != 4'b0000);
    flush            = (state_q == ORIG) && !ena;
    count_after_push = buf_count_q + CW'(push);
    case (state_q)
      IDLE: begin
        if (ena) state_d = ORIG;
      end
      ORIG: begin
        if (!ena) begin
          state_d = IDLE;
        end else if ((exec_dup && (count_after_push != '0)) || (count_after_push == FULL)) begin
          state_d = REPLAY;
        end
      end
      REPLAY: begin
        if ((buf_count_q == '0) || (pop && (buf_count_q == CW'(1)))) begin
          state_d = ena ? ORIG : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register, buffer storage, pointers and sticky violation flag
  always_comb begin
    out_valid_d      = out_valid_q;
    out_instr_d      = out_instr_q;
    out_is_dup_d     = out_is_dup_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    buf_count_d      = buf_count_q;
    orig_violation_d = orig_violation_q;
    buf_d            = buf_q;
    live_d           = 1'b1;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_instr_d  = bus.in_instr;
      out_is_dup_d = 1'b0;
    end else if (pop) begin
      out_valid_d  = 1'b1;
      out_instr_d  = remap(buf_q[rd_ptr_q]);
      out_is_dup_d = 1'b1;
    end else if (slot_free) begin
      out_valid_d  = 1'b0;
    end
    if (push) begin
      buf_d[wr_ptr_q] = bus.in_instr;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      buf_count_d     = buf_count_q + CW'(1);
      if (uses_upper(bus.in_instr)) orig_violation_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      buf_count_d = buf_count_q - CW'(1);
    end
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      buf_count_d = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      out_valid_q      <= 1'b0;
      out_instr_q      <= '0;
      out_is_dup_q     <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      buf_count_q      <= '0;
      orig_violation_q <= 1'b0;
      live_q           <= 1'b0;
      for (int k = 0; k < DEPTH; k++) buf_q[k] <= '0;
    end else begin
      state_q          <= state_d;
      out_valid_q      <= out_valid_d;
      out_instr_q      <= out_instr_d;
      out_is_dup_q     <= out_is_dup_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      buf_count_q      <= buf_count_d;
      orig_violation_q <= orig_violation_d;
      live_q           <= live_d;
      buf_q            <= buf_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_is_dup  = out_is_dup_q;
  assign buf_count       = buf_count_q;
  assign orig_violation  = orig_violation_q;

endmodule

// File: tb/tb_qed_dup_replay.sv
// Directed bench for qed_dup_replay: vector table plus hand-written multi-cycle sequences.
module tb_qed_dup_replay;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       exec_dup;
  logic [3:0] buf_count;
  logic       orig_violation;

  int total = 0;
  int bad   = 0;

  qed_dup_replay_if bus ();

  qed_dup_replay dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .exec_dup       (exec_dup),
    .bus            (bus),
    .buf_count      (buf_count),
    .orig_violation (orig_violation)
  );

  typedef struct {
    logic        ena;
    logic        exec_dup;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic        exp_dup;
    logic [3:0]  exp_count;
    logic        exp_viol;
  } vec_t;

  vec_t vq[$];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] addi_orig(input int k);
    return {12'(k), 5'd1, 3'd0, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] addi_dup(input int k);
    return {2'b01, 10'(k), 5'd17, 3'd0, 5'd19, 7'b0010011};
  endfunction

  function automatic void addVec(input logic e, input logic x, input logic iv,
                                 input logic [31:0] ii, input logic ordy,
                                 input logic erdy, input logic ev, input logic [31:0] ei,
                                 input logic ed, input logic [3:0] ec, input logic evl);
    vec_t v;
    v.ena = e; v.exec_dup = x; v.in_valid = iv; v.in_instr = ii; v.out_ready = ordy;
    v.exp_in_ready = erdy; v.exp_valid = ev; v.exp_instr = ei; v.exp_dup = ed;
    v.exp_count = ec; v.exp_viol = evl;
    vq.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic x, input logic iv,
                               input logic [31:0] ii, input logic ordy);
    ena          = e;
    exec_dup     = x;
    bus.in_valid = iv;
    bus.in_instr = ii;
    bus.out_ready = ordy;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v.ena, v.exec_dup, v.in_valid, v.in_instr, v.out_ready);
    #1;
    checkOutput($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 32'(v.exp_in_ready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      checkOutput($sformatf("v%0d out_instr", idx), bus.out_instr, v.exp_instr);
      checkOutput($sformatf("v%0d out_is_dup", idx), 32'(bus.out_is_dup), 32'(v.exp_dup));
    end
    checkOutput($sformatf("v%0d buf_count", idx), 32'(buf_count), 32'(v.exp_count));
    checkOutput($sformatf("v%0d violation", idx), 32'(orig_violation), 32'(v.exp_viol));
  endtask

  // Main sequence
  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset buf_count", 32'(buf_count), 32'd0);
    checkOutput("reset violation", 32'(orig_violation), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    // ena, exec, iv, instr, ordy | in_ready, valid, instr, dup, count, viol
    addVec(1, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 1, 32'h00508193, 1, 1, 1, 32'h00508193, 0, 1, 0);
    addVec(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 1, 0);
    addVec(1, 0, 0, 32'h0,        1, 0, 1, 32'h40588993, 1, 0, 0);
    addVec(1, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 1, 32'h002002B3, 1, 1, 1, 32'h002002B3, 0, 1, 0);
    addVec(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 1, 0);
    addVec(1, 0, 0, 32'h0,        1, 0, 1, 32'h01200AB3, 1, 0, 0);
    addVec(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 1, 32'h000012B7, 1, 1, 1, 32'h000012B7, 0, 0, 0);
    addVec(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 1, 32'h0020A423, 1, 1, 1, 32'h0020A423, 0, 1, 0);
    addVec(1, 0, 1, 32'h0043A303, 1, 1, 1, 32'h0043A303, 0, 2, 0);
    addVec(1, 1, 0, 32'h0,        1, 1, 0, 32'h0,        0, 2, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 1, 32'h4128A423, 1, 1, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 1, 32'h4128A423, 1, 1, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 1, 32'h4128A423, 1, 1, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 1, 32'h4128A423, 1, 1, 0);
    addVec(1, 0, 0, 32'h0,        1, 0, 1, 32'h404BAB03, 1, 0, 0);
    addVec(1, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 1, 32'h00508193, 1, 1, 1, 32'h00508193, 0, 1, 0);
    addVec(1, 0, 1, 32'h00508193, 1, 1, 1, 32'h00508193, 0, 2, 0);
    addVec(1, 0, 1, 32'h00508193, 1, 1, 1, 32'h00508193, 0, 3, 0);
    addVec(0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);
    addVec(0, 0, 1, 32'h002002B3, 1, 1, 1, 32'h002002B3, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0);

    for (int i = 0; i < vq.size(); i++) runVector(vq[i], i);

    // Fill the buffer without exec_dup and watch the automatic replay
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, addi_orig(k), 1'b1);
      #1;
      checkOutput($sformatf("fill%0d in_ready", k), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("fill%0d out_instr", k), bus.out_instr, addi_orig(k));
      checkOutput($sformatf("fill%0d buf_count", k), 32'(buf_count), 32'(k + 1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("full in_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("drain%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("drain%0d out_instr", k), bus.out_instr, addi_dup(k));
      checkOutput($sformatf("drain%0d out_is_dup", k), 32'(bus.out_is_dup), 32'd1);
      checkOutput($sformatf("drain%0d buf_count", k), 32'(buf_count), 32'(7 - k));
    end
    checkOutput("drained in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("drained out_valid", 32'(bus.out_valid), 32'd0);

    // Upper-register original, then reset in the middle of its replay
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00108893, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("viol set", 32'(orig_violation), 32'd1);
    checkOutput("viol buf_count", 32'(buf_count), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00508193, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("viol sticky", 32'(orig_violation), 32'd1);
    checkOutput("viol buf_count3", 32'(buf_count), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("viol dup instr", bus.out_instr, {12'h401, 5'd17, 3'd0, 5'd17, 7'b0010011});
    checkOutput("viol dup flag", 32'(bus.out_is_dup), 32'd1);
    checkOutput("mid-replay buf_count", 32'(buf_count), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst mid buf_count", 32'(buf_count), 32'd0);
    checkOutput("rst mid violation", 32'(orig_violation), 32'd0);
    checkOutput("rst mid in_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("idle%0d in_ready", k), 32'(bus.in_ready), 32'd1);
      checkOutput($sformatf("idle%0d out_valid", k), 32'(bus.out_valid), 32'd0);
      checkOutput($sformatf("idle%0d buf_count", k), 32'(buf_count), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
